// File: rtl/rv_alu_seq.sv
// rv_alu_seq: handshaked RISC-V R-type ALU with optional iterative M ops.
// Define RV_ALU_MDIV_EN to build MUL/MULHU/DIVU/REMU; otherwise m=1 ops are illegal.
`timescale 1ns/1ps
module rv_alu_seq #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [4:0]      in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal
);

`ifdef RV_ALU_MDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
`else
    typedef enum logic {S_IDLE, S_DONE} state_t;
`endif

    state_t          r_state;
    state_t          w_nstate;
    state_t          w_acc_state;
    logic [XLEN-1:0] r_result;
    logic            r_illegal;
    logic [XLEN-1:0] w_sc_res;
    logic            w_sc_ill;
    logic            w_is_mop;
    logic            w_accept;
    logic [SHW-1:0]  w_shamt;
    logic            w_last;

`ifdef RV_ALU_MDIV_EN
    logic [SHW-1:0]  r_cnt;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;
    logic [1:0]      r_mop;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_sh;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_nx_hi;
    logic [XLEN-1:0] w_nx_lo;
    logic [XLEN-1:0] w_mres;
`endif

    assign w_shamt     = in_b[SHW-1:0];
    assign w_accept    = in_valid && in_ready;
    assign out_valid   = (r_state == S_DONE);
    assign out_result  = r_result;
    assign out_illegal = r_illegal;

    // Decode the op and compute every single-cycle result from the live inputs.
    always_comb begin
        w_sc_res = '0;
        w_sc_ill = 1'b0;
        w_is_mop = 1'b0;
        if (!in_op[4]) begin
            case (in_op[3:0])
                4'b0000: w_sc_res = in_a + in_b;
                4'b1000: w_sc_res = in_a - in_b;
                4'b0001: w_sc_res = in_a << w_shamt;
                4'b0101: w_sc_res = in_a >> w_shamt;
                4'b1101: w_sc_res = XLEN'($signed(in_a) >>> w_shamt);
                4'b0010: w_sc_res = {{(XLEN-1){1'b0}},
                                     ($signed(in_a) < $signed(in_b))};
                4'b0011: w_sc_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
                4'b0100: w_sc_res = in_a ^ in_b;
                4'b0110: w_sc_res = in_a | in_b;
                4'b0111: w_sc_res = in_a & in_b;
                default: w_sc_ill = 1'b1;
            endcase
        end else begin
`ifdef RV_ALU_MDIV_EN
            if (!in_op[3] && (in_op[2:0] == 3'b000 || in_op[2:0] == 3'b011 ||
                              in_op[2:0] == 3'b101 || in_op[2:0] == 3'b111))
                w_is_mop = 1'b1;
            else
                w_sc_ill = 1'b1;
`else
            w_sc_ill = 1'b1;
`endif
        end
    end

`ifdef RV_ALU_MDIV_EN
    assign w_last = (r_state == S_BUSY) && (r_cnt == SHW'(XLEN-1));

    // One shift-add or restoring-divide step; {r_hi,r_lo} is the working pair.
    always_comb begin
        w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_sh   = {r_hi, r_lo[XLEN-1]};
        w_diff = w_sh - {1'b0, r_b};
        w_ge   = !w_diff[XLEN];
        if (r_mop[1]) begin
            w_nx_hi = w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
            w_nx_lo = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_nx_hi = w_sum[XLEN:1];
            w_nx_lo = {w_sum[0], r_lo[XLEN-1:1]};
        end
        w_mres = r_mop[0] ? w_nx_hi : w_nx_lo;
    end

    // Iteration registers: load on accept of an M op, step while busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_mop <= '0;
        end else if (w_accept && w_is_mop) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= in_a;
            r_b   <= in_b;
            r_mop <= in_op[2:1];
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + 1'b1;
            r_hi  <= w_nx_hi;
            r_lo  <= w_nx_lo;
        end
    end

    assign w_acc_state = w_is_mop ? S_BUSY : S_DONE;
`else
    assign w_last      = 1'b0;
    assign w_acc_state = S_DONE;
`endif

    // Next state and input-side ready.
    always_comb begin
        w_nstate = r_state;
        in_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_nstate = w_acc_state;
            end
`ifdef RV_ALU_MDIV_EN
            S_BUSY: begin
                if (w_last)
                    w_nstate = S_DONE;
            end
`endif
            S_DONE: begin
                in_ready = out_ready;
                if (out_ready)
                    w_nstate = in_valid ? w_acc_state : S_IDLE;
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_nstate;
    end

    // Result register: written on single-cycle accept or final M step, else held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept && !w_is_mop) begin
            r_result  <= w_sc_res;
            r_illegal <= w_sc_ill;
        end
`ifdef RV_ALU_MDIV_EN
        else if (w_last) begin
            r_result  <= w_mres;
            r_illegal <= 1'b0;
        end
`endif
    end

endmodule

// File: doc/rv_alu_seq.md
Name: rv_alu_seq

Overview:
- Parametrised, handshaked successor to the combinational R-type ALU in the RISC-V execute stage.
- Registers operands and produces the result on a valid/ready output channel.
- Adds signed/unsigned compare, correct arithmetic shift, an illegal-op flag and optional iterative M-extension ops (MUL, MULHU, DIVU, REMU).
- Sits between decode/issue and writeback, and absorbs multi-cycle latency via backpressure.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SHW, $clog2(XLEN), shift-amount width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block accepts; transfer when in_valid && in_ready.
- in_a  input  XLEN  operand rs1.
- in_b  input  XLEN  operand rs2.
- in_op  input  5  {m, funct7[5], funct3}; m = funct7[0].
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
- out_result  output  XLEN  result.
- out_illegal  output  1  op not supported; qualifies out_result (forced 0).

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, out_valid=0, out_result=0, out_illegal=0, iteration counter=0. Reset mid-BUSY abandons the operation; no output is produced.
- States:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0, iterating.
  - DONE: out_valid=1; in_ready=out_ready.
- Transitions:
  - IDLE --accept single-cycle/illegal op--> DONE.
  - IDLE --accept M op--> BUSY.
  - BUSY --counter==XLEN-1--> DONE.
  - DONE --out_ready && !in_valid--> IDLE.
  - DONE --out_ready && in_valid--> DONE (single-cycle op) or BUSY (M op). Back-to-back single-cycle throughput is 1 per clock.
- Latency, accept edge to out_valid: single-cycle ops 1 clk; M ops XLEN+1 clk.
- out_result and out_illegal hold stable while out_valid && !out_ready. Inputs are sampled only on the accept edge.
- Single-cycle ops, by {funct7[5],funct3} with m=0:
  - 0000 ADD; 1000 SUB, both mod 2^XLEN.
  - 0001 SLL; 0101 SRL; 1101 SRA (sign-fill). Shift amount = in_b[SHW-1:0]; upper bits ignored.
  - 0010 SLT signed; 0011 SLTU unsigned. Result is zero-extended 0/1.
  - 0100 XOR; 0110 OR; 0111 AND.
  - Any other code with m=0: illegal.
- M ops (m=1, funct7[5]=0), all unsigned, one bit per clock:
  - 000 MUL: low XLEN bits of product, shift-add.
  - 011 MULHU: high XLEN bits.
  - 101 DIVU: restoring division, quotient.
  - 111 REMU: remainder.
  - Divide by zero: DIVU gives all-ones, REMU gives in_a. Still takes XLEN+1 clk.
  - m=1 with funct7[5]=1, or with another funct3: illegal.
- Illegal op: behaves as a single-cycle op; out_illegal=1, out_result=0.
- in_valid while BUSY is ignored (in_ready=0); the upstream stage must hold.

Optional Feature:
- Macro RV_ALU_MDIV_EN.
- Defined: M ops implemented as above; BUSY state and iteration datapath present.
- Undefined: no BUSY state or multiply/divide logic; every m=1 op is illegal with single-cycle latency (out_illegal=1, out_result=0).

Test Plan:
- XLEN=32, ADD 0x7FFFFFFF+0x00000001 -> out_valid 1 clk after accept, out_result=0x80000000, out_illegal=0; SUB 0x0-0x1 -> 0xFFFFFFFF.
- SRA 0x80000000 by in_b=0x00000024 (shamt=4) -> 0xF8000000; SRL same -> 0x08000000; SLT 0xFFFFFFFF<0x1 -> 1; SLTU same -> 0.
- Back-to-back XOR, OR, AND with out_ready held 1 -> 3 results on 3 consecutive clocks; out_ready=0 for 4 clks -> result held stable, in_ready=0.
- MACRO defined: MUL 0x0001_0000*0x0001_0000 -> 0x00000000, and MULHU of same -> 0x00000001, each after 33 clk; DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- in_op=5'b01010 (SUB-variant of SLT) -> out_illegal=1, out_result=0 after 1 clk; with macro undefined, MUL -> out_illegal=1 after 1 clk.
- rst_n low for 1 clk at cycle 10 of a DIVU -> next cycle out_valid=0, in_ready=1; the following ADD completes normally.
